// File: rtl/reg_bank_if.sv
// Bus bundle for reg_bank: op strobe/select/data in, two read ports and the
// registered shift-out and carry flags out.
//
// Handshake: load acts as a valid with an always-ready receiver. An op
// (mode, waddr, din, sin) is accepted on every rising clk edge where
// load=1 and rst=0. There is no back-pressure and no ready signal. The op
// fields only need to be stable around that edge.
interface reg_bank_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
);
  logic             load;
  logic [2:0]       mode;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] din;
  logic             sin;
  logic [AW-1:0]    raddr_a;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] dout_a;
  logic [WIDTH-1:0] dout_b;
  logic             sout;
  logic             carry;

  modport master (
    output load, mode, waddr, din, sin, raddr_a, raddr_b,
    input  dout_a, dout_b, sout, carry
  );

  modport slave (
    input  load, mode, waddr, din, sin, raddr_a, raddr_b,
    output dout_a, dout_b, sout, carry
  );
endinterface

// File: rtl/reg_bank.sv
// reg_bank: DEPTH registers of WIDTH bits with one op port and two
// combinational read ports. Ops are hold, load, shift left/right,
// rotate left/right, increment and clear, applied to one register per cycle.
// sout captures the bit pushed out by the last shift/rotate. carry flags an
// increment that wrapped.
// AW must equal ceil(log2(DEPTH)). Addresses at or above DEPTH read as zero,
// and writes to them are dropped. The flags still update, treating the
// missing register's old value as zero.
module reg_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic     clk,
  input  logic     rst,
  reg_bank_if.slave bus
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic             sout_q, sout_d;
  logic             carry_q, carry_d;

  logic [WIDTH-1:0] old_val;
  logic [WIDTH-1:0] new_val;

  // Fetch the target register's current contents. Out-of-range addresses yield zero.
  always_comb begin
    old_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.waddr == AW'(i)) begin
        old_val = regs_q[i];
      end
    end
  end

  // Op datapath: compute the new register value and the next flag values.
  always_comb begin
    new_val = old_val;
    sout_d  = sout_q;
    carry_d = 1'b0;
    case (bus.mode)
      MODE_HOLD: new_val = old_val;
      MODE_LOAD: new_val = bus.din;
      MODE_SHL: begin
        new_val = {old_val[WIDTH-2:0], bus.sin};
        sout_d  = old_val[WIDTH-1];
      end
      MODE_SHR: begin
        new_val = {bus.sin, old_val[WIDTH-1:1]};
        sout_d  = old_val[0];
      end
      MODE_ROL: begin
        new_val = {old_val[WIDTH-2:0], old_val[WIDTH-1]};
        sout_d  = old_val[WIDTH-1];
      end
      MODE_ROR: begin
        new_val = {old_val[0], old_val[WIDTH-1:1]};
        sout_d  = old_val[0];
      end
      MODE_INC: begin
        new_val = old_val + WIDTH'(1);
        carry_d = &old_val;
      end
      MODE_CLR: new_val = '0;
      default:  new_val = old_val;
    endcase
    // Without a strobe, both flags keep their state.
    if (!bus.load) begin
      sout_d  = sout_q;
      carry_d = carry_q;
    end
  end

  // Next register contents: only the addressed register changes, and only on load.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (bus.load) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.waddr == AW'(i)) begin
          regs_d[i] = new_val;
        end
      end
    end
  end

  // State registers. Reset clears everything immediately, so no partial op survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      sout_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      sout_q  <= sout_d;
      carry_q <= carry_d;
    end
  end

  // Read port A: combinational, no bypass of the pending op.
  always_comb begin
    bus.dout_a = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.raddr_a == AW'(i)) begin
        bus.dout_a = regs_q[i];
      end
    end
  end

  // Read port B: identical to port A and independently addressed.
  always_comb begin
    bus.dout_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.raddr_b == AW'(i)) begin
        bus.dout_b = regs_q[i];
      end
    end
  end

  assign bus.sout  = sout_q;
  assign bus.carry = carry_q;

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank. Two instances, DEPTH=4 and DEPTH=3, share one stimulus
// stream. An arithmetic reference model tracks the register contents and
// flags for each instance.
module tb_reg_bank;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  logic       load;
  logic [2:0] mode;
  logic [1:0] waddr;
  logic [7:0] din;
  logic       sin;
  logic [1:0] raddr_a;
  logic [1:0] raddr_b;

  reg_bank_if #(.WIDTH(8), .AW(2)) b4 ();
  reg_bank_if #(.WIDTH(8), .AW(2)) b3 ();

  assign b4.load = load;    assign b3.load = load;
  assign b4.mode = mode;    assign b3.mode = mode;
  assign b4.waddr = waddr;  assign b3.waddr = waddr;
  assign b4.din = din;      assign b3.din = din;
  assign b4.sin = sin;      assign b3.sin = sin;
  assign b4.raddr_a = raddr_a;  assign b3.raddr_a = raddr_a;
  assign b4.raddr_b = raddr_b;  assign b3.raddr_b = raddr_b;

  reg_bank #(.WIDTH(8), .DEPTH(4), .AW(2)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  reg_bank #(.WIDTH(8), .DEPTH(3), .AW(2)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  int m4 [4];
  int m3 [3];
  int s4 = 0, c4 = 0, s3 = 0, c3 = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input int exp);
    logic [7:0] e;
    e = exp[7:0];
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, e);
    end
  endtask

  // Op semantics expressed as plain arithmetic on an 8-bit value.
  function automatic void step_model(input int md, input int old, input int dn, input int sn,
                                     input int so_old, output int nv, output int so, output int co);
    nv = old;
    so = so_old;
    co = 0;
    case (md)
      1: nv = dn;
      2: begin nv = (old * 2) % 256 + sn;       so = old / 128; end
      3: begin nv = old / 2 + sn * 128;         so = old % 2;   end
      4: begin nv = (old * 2) % 256 + old / 128; so = old / 128; end
      5: begin nv = old / 2 + (old % 2) * 128;  so = old % 2;   end
      6: begin nv = (old + 1) % 256; co = (old == 255) ? 1 : 0; end
      7: nv = 0;
      default: ;
    endcase
  endfunction

  task automatic model_apply(input int md, input int wa, input int dn, input int sn);
    int nv, so, co, old;
    step_model(md, m4[wa], dn, sn, s4, nv, so, co);
    m4[wa] = nv; s4 = so; c4 = co;
    old = (wa < 3) ? m3[wa] : 0;
    step_model(md, old, dn, sn, s3, nv, so, co);
    if (wa < 3) m3[wa] = nv;
    s3 = so; c3 = co;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m4[i] = 0;
    for (int i = 0; i < 3; i++) m3[i] = 0;
    s4 = 0; c4 = 0; s3 = 0; c3 = 0;
  endtask

  function automatic int exp3(input int a);
    return (a < 3) ? m3[a] : 0;
  endfunction

  // Sweep every address on both read ports of both instances, then check the flags.
  task automatic check_all(input string tag);
    for (int a = 0; a < 4; a++) begin
      raddr_a = 2'(a);
      raddr_b = 2'(3 - a);
      #1;
      chk({tag, "/d4a"}, b4.dout_a, m4[a]);
      chk({tag, "/d4b"}, b4.dout_b, m4[3 - a]);
      chk({tag, "/d3a"}, b3.dout_a, exp3(a));
      chk({tag, "/d3b"}, b3.dout_b, exp3(3 - a));
    end
    chk({tag, "/d4sout"}, {7'd0, b4.sout}, s4);
    chk({tag, "/d4carry"}, {7'd0, b4.carry}, c4);
    chk({tag, "/d3sout"}, {7'd0, b3.sout}, s3);
    chk({tag, "/d3carry"}, {7'd0, b3.carry}, c3);
  endtask

  // ---------------- driver tasks ----------------
  task automatic op(input logic ld, input logic [2:0] md, input logic [1:0] wa,
                    input logic [7:0] dn, input logic sn, input string tag);
    @(negedge clk);
    load = ld; mode = md; waddr = wa; din = dn; sin = sn;
    raddr_a = wa; raddr_b = wa;
    #1;
    // Before the edge, a read of the target must still return the old value.
    chk({tag, "/pre4"}, b4.dout_a, m4[wa]);
    chk({tag, "/pre3"}, b3.dout_b, exp3(int'(wa)));
    @(posedge clk);
    #1;
    load = 1'b0;
    if (ld) model_apply(int'(md), int'(wa), int'(dn), int'(sn));
    check_all(tag);
  endtask

  task automatic expect_reg(input string tag, input logic [1:0] a, input logic [7:0] v);
    raddr_a = a;
    #1;
    chk(tag, b4.dout_a, int'(v));
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #2;
    rst = 1'b1;
    load = 1'b1; mode = 3'b001; din = 8'($urandom); waddr = 2'($urandom);
    model_reset();
    #1;
    check_all({tag, "/async"});
    @(posedge clk);
    #1;
    check_all({tag, "/held"});
    @(negedge clk);
    rst = 1'b0;
    load = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1;
    load = 1'b0; mode = 3'b000; waddr = 2'd0; din = 8'h00; sin = 1'b0;
    raddr_a = 2'd0; raddr_b = 2'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Load and read on both ports.
    op(1'b1, 3'b001, 2'd2, 8'hA5, 1'b0, "ld2");
    op(1'b1, 3'b001, 2'd1, 8'h3C, 1'b0, "ld1");
    expect_reg("ld_r2", 2'd2, 8'hA5);
    expect_reg("ld_r1", 2'd1, 8'h3C);
    expect_reg("ld_r0", 2'd0, 8'h00);

    // Shift / rotate chain on reg 0.
    op(1'b1, 3'b001, 2'd0, 8'h81, 1'b0, "sr_ld");
    op(1'b1, 3'b010, 2'd0, 8'h00, 1'b0, "shl");
    expect_reg("shl_v", 2'd0, 8'h02);
    chk("shl_sout", {7'd0, b4.sout}, 1);
    op(1'b1, 3'b101, 2'd0, 8'h00, 1'b0, "ror");
    expect_reg("ror_v", 2'd0, 8'h01);
    chk("ror_sout", {7'd0, b4.sout}, 0);
    op(1'b1, 3'b011, 2'd0, 8'h00, 1'b1, "shr");
    expect_reg("shr_v", 2'd0, 8'h80);
    chk("shr_sout", {7'd0, b4.sout}, 1);
    op(1'b1, 3'b001, 2'd0, 8'h00, 1'b0, "ld0");
    chk("ld_sout_hold", {7'd0, b4.sout}, 1);

    // Increment wrap and carry clearing.
    op(1'b1, 3'b001, 2'd3, 8'hFE, 1'b0, "inc_ld");
    op(1'b1, 3'b110, 2'd3, 8'h00, 1'b0, "inc1");
    chk("inc1_carry", {7'd0, b4.carry}, 0);
    op(1'b1, 3'b110, 2'd3, 8'h00, 1'b0, "inc2");
    expect_reg("inc2_v", 2'd3, 8'h00);
    chk("inc2_carry", {7'd0, b4.carry}, 1);
    op(1'b1, 3'b000, 2'd3, 8'h00, 1'b0, "hold");
    chk("hold_carry", {7'd0, b4.carry}, 0);

    // No bypass and load gating.
    op(1'b1, 3'b111, 2'd1, 8'h00, 1'b0, "clr1");
    op(1'b1, 3'b001, 2'd1, 8'h55, 1'b0, "ld55");
    for (int k = 0; k < 3; k++) op(1'b0, 3'b111, 2'd1, 8'hFF, 1'b1, "gate");
    expect_reg("gate_v", 2'd1, 8'h55);

    // Async reset with both flags set.
    op(1'b1, 3'b001, 2'd2, 8'h80, 1'b0, "rs_ld");
    op(1'b1, 3'b010, 2'd2, 8'h00, 1'b0, "rs_shl");
    op(1'b1, 3'b001, 2'd3, 8'hFF, 1'b0, "rs_ldff");
    op(1'b1, 3'b110, 2'd3, 8'h00, 1'b0, "rs_inc");
    chk("rs_pre_sout", {7'd0, b4.sout}, 1);
    chk("rs_pre_carry", {7'd0, b4.carry}, 1);
    do_reset("rst1");

    // Out-of-range write on the DEPTH=3 instance.
    op(1'b1, 3'b001, 2'd0, 8'h11, 1'b0, "oor0");
    op(1'b1, 3'b001, 2'd1, 8'h22, 1'b0, "oor1");
    op(1'b1, 3'b001, 2'd2, 8'h33, 1'b0, "oor2");
    op(1'b1, 3'b001, 2'd3, 8'hFF, 1'b0, "oor3");
    raddr_a = 2'd3;
    #1;
    chk("oor_rd3", b3.dout_a, 0);

    // Randomised ops with occasional resets.
    for (int n = 0; n < 300; n++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      op(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
         d, 1'($urandom_range(0, 1)), "rnd");
      if ($urandom_range(0, 49) == 0) do_reset("rnd_rst");
    end

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter WIDTH, default 8, data width of each register (>= 2).
REQ-002 Parameter DEPTH, default 4, number of registers (>= 2).
REQ-003 Parameter AW, default 2, address width; SHALL equal ceil(log2(DEPTH)).
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 LOAD  input  1  operation strobe; op executes on a rising CLK edge only when LOAD=1.
REQ-007 MODE  input  3  operation select (REQ-011).
REQ-008 WADDR  input  AW  target register of the operation.
REQ-009 DIN  input  WIDTH  parallel load data.
REQ-010 SIN  input  1  serial input bit for shift ops.
REQ-011 RADDR_A, RADDR_B  input  AW each  read addresses, ports A and B.
REQ-012 DOUT_A, DOUT_B  output  WIDTH each  read data, ports A and B.
REQ-013 SOUT  output  1  registered bit shifted/rotated out by the last shift/rotate op.
REQ-014 CARRY  output  1  registered wrap flag from the last accepted op.

Function
REQ-015 MODE decode, applied to register WADDR when LOAD=1: 000 hold; 001 load DIN; 010 shift left, SIN into bit 0; 011 shift right, SIN into bit WIDTH-1; 100 rotate left; 101 rotate right; 110 increment modulo 2^WIDTH; 111 clear to 0.
REQ-016 Only register WADDR SHALL change on an accepted op; all other registers hold.
REQ-017 LOAD=0: no register, SOUT or CARRY change, regardless of MODE, WADDR, DIN, SIN.
REQ-018 Shift/rotate left: SOUT <= old bit WIDTH-1; shift/rotate right: SOUT <= old bit 0; same edge as register update.
REQ-019 SOUT SHALL hold its value on accepted ops with MODE not in {010,011,100,101}.
REQ-020 Increment: CARRY <= 1 only if old value was all-ones (result wraps to 0); otherwise CARRY <= 0.
REQ-021 CARRY <= 0 on every accepted op with MODE != 110, including MODE 000.
REQ-022 Reads combinational: DOUT_A = register[RADDR_A], DOUT_B = register[RADDR_B]; both ports may address the same register.
REQ-023 No write-through bypass: a read of WADDR in the cycle of an accepted op returns the pre-op value; new value visible after the edge.
REQ-024 WADDR >= DEPTH (non-power-of-2 DEPTH): accepted op SHALL be ignored, no register change; SOUT and CARRY still follow REQ-018..REQ-021 as if old value were 0.
REQ-025 RADDR_A/RADDR_B >= DEPTH: corresponding DOUT SHALL be all zeros.
REQ-026 Latency: one CLK edge from accepted op to updated register, SOUT, CARRY; throughput one op per cycle, back-to-back ops on the same register use the updated value.

Reset
REQ-027 RESET=1 SHALL immediately, without a clock edge, force all registers to 0, SOUT to 0, CARRY to 0.
REQ-028 While RESET=1, LOAD SHALL be ignored; an op presented on the edge where RESET is asserted or still high is discarded.
REQ-029 First op accepted on the first rising CLK edge with RESET=0 and LOAD=1.
REQ-030 RESET asserted mid-sequence (e.g. during back-to-back shifts) SHALL leave no partial state; all outputs read 0 until next accepted op.

Verification (WIDTH=8, DEPTH=4)
REQ-031 Load/read: load 0xA5 to reg 2, 0x3C to reg 1; RADDR_A=2, RADDR_B=1 -> DOUT_A=0xA5, DOUT_B=0x3C; regs 0, 3 remain 0x00.
REQ-032 Shift/rotate: reg 0=0x81; shift left SIN=0 -> 0x02, SOUT=1; rotate right -> 0x01, SOUT=0; shift right SIN=1 -> 0x80, SOUT=1; then load 0x00 -> SOUT stays 1.
REQ-033 Increment wrap: reg 3=0xFE; increment -> 0xFF, CARRY=0; increment -> 0x00, CARRY=1; MODE 000 with LOAD=1 -> CARRY=0, reg 3=0x00.
REQ-034 No-bypass/LOAD gating: load 0x55 to reg 1 with RADDR_A=1 -> DOUT_A=0x00 before edge, 0x55 after; LOAD=0, MODE=111 for 3 cycles -> reg 1 stays 0x55.
REQ-035 Async reset: regs loaded, SOUT=1, CARRY=1; assert RESET between clock edges -> all DOUT, SOUT, CARRY = 0 before next edge; LOAD=1 while RESET=1 -> no change.
REQ-036 Non-power-of-2 (DEPTH=3, AW=2): load 0xFF to WADDR=3 -> regs 0..2 unchanged; RADDR_A=3 -> DOUT_A=0x00.
